// File: rtl/image_page_pingpong.sv
// Two-page ping-pong pixel store: raster-order beat writes into one page while
// unaligned strips are read from the other page with one cycle of latency.
module image_page_pingpong #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int DEPTH  = IMG_W * IMG_H,
    parameter int WR_PIX = 8,
    parameter int RD_PIX = 10,
    parameter int ADDR_W = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [WR_PIX*PIX_W-1:0]   wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [RD_PIX*PIX_W-1:0]   rd_data,
    output logic                      rd_valid,
    output logic                      rd_page_valid,
    input  logic                      rd_release,
    output logic                      rd_err
);
    // Pixels are spread over NB single-pixel banks (pixel p -> bank p mod NB),
    // so any WR_PIX- or RD_PIX-long run of consecutive pixels hits distinct banks.
    localparam int NB_MIN = (WR_PIX > RD_PIX) ? WR_PIX : RD_PIX;
    localparam int LOG_NB = $clog2(NB_MIN);
    localparam int NB     = 1 << LOG_NB;
    localparam int ROW_W  = ADDR_W - LOG_NB;
    localparam int BEATS  = DEPTH / WR_PIX;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW     = ADDR_W + 1;

    logic [1:0]              r_full;
    logic [1:0]              w_full_next;
    logic                    r_wr_sel;
    logic                    r_rd_sel;
    logic [CNT_W-1:0]        r_wr_cnt;
    logic                    r_rd_valid;
    logic                    r_rd_err;
    logic [LOG_NB-1:0]       r_rd_lo;
    logic [RD_PIX-1:0]       r_pad;
    logic [RD_PIX-1:0]       w_pad_next;
    logic [ADDR_W-1:0]       w_wr_base;
    logic                    w_wr_fire;
    logic                    w_wr_last;
    logic                    w_rd_fire;
    logic                    w_rel;
    logic [PIX_W-1:0]        w_bank_q [NB];

    assign wr_ready      = !r_full[r_wr_sel];
    assign rd_page_valid = r_full[r_rd_sel];
    assign rd_valid      = r_rd_valid;
    assign rd_err        = r_rd_err;

    assign w_wr_fire = wr_valid && wr_ready;
    assign w_wr_last = w_wr_fire && (r_wr_cnt == CNT_W'(BEATS - 1));
    assign w_rd_fire = rd_en && rd_page_valid;
    assign w_rel     = rd_release && rd_page_valid;
    assign w_wr_base = ADDR_W'(r_wr_cnt) * ADDR_W'(WR_PIX);

    // The write page is never full, so completion and release touch different pages.
    always_comb begin
        w_full_next = r_full;
        if (w_rel)
            w_full_next[r_rd_sel] = 1'b0;
        if (w_wr_last)
            w_full_next[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_lo    <= '0;
            r_pad      <= '1;
        end else begin
            r_full     <= w_full_next;
            r_rd_valid <= w_rd_fire;
            if (w_wr_fire)
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
            if (w_wr_last)
                r_wr_sel <= !r_wr_sel;
            if (w_rel)
                r_rd_sel <= !r_rd_sel;
            if (rd_en && !rd_page_valid)
                r_rd_err <= 1'b1;
            if (w_rd_fire) begin
                r_rd_lo <= rd_addr[LOG_NB-1:0];
                r_pad   <= w_pad_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            logic [PIX_W-1:0]  r_mem [0:(2**(ROW_W+1))-1];
            logic [PIX_W-1:0]  r_q;
            logic [LOG_NB-1:0] w_k;
            logic [LOG_NB-1:0] w_lane;
            logic [ADDR_W-1:0] w_waddr;
            logic [ROW_W-1:0]  w_wrow;
            logic              w_we;
            logic [LOG_NB-1:0] w_roff;
            logic [PW-1:0]     w_raddr;
            logic [ROW_W-1:0]  w_rrow;

            // Which lane of the beat (if any) and which strip position land in this bank.
            assign w_k     = LOG_NB'(gi) - w_wr_base[LOG_NB-1:0];
            assign w_we    = w_wr_fire && (int'(w_k) < WR_PIX);
            assign w_lane  = (int'(w_k) < WR_PIX) ? w_k : '0;
            assign w_waddr = w_wr_base + ADDR_W'(w_k);
            assign w_wrow  = ROW_W'(w_waddr >> LOG_NB);
            assign w_roff  = LOG_NB'(gi) - rd_addr[LOG_NB-1:0];
            assign w_raddr = PW'(rd_addr) + PW'(w_roff);
            assign w_rrow  = ROW_W'(w_raddr >> LOG_NB);

            always_ff @(posedge clk) begin
                if (w_we)
                    r_mem[{r_wr_sel, w_wrow}] <= wr_data[int'(w_lane)*PIX_W +: PIX_W];
                if (w_rd_fire)
                    r_q <= r_mem[{r_rd_sel, w_rrow}];
            end

            assign w_bank_q[gi] = r_q;
        end

        for (gi = 0; gi < RD_PIX; gi++) begin : g_strip
            logic [LOG_NB-1:0] w_sel;

            assign w_pad_next[gi] = (PW'(rd_addr) + PW'(gi)) >= PW'(DEPTH);
            assign w_sel          = r_rd_lo + LOG_NB'(gi);
            assign rd_data[gi*PIX_W +: PIX_W] = r_pad[gi] ? '0 : w_bank_q[w_sel];
        end
    endgenerate

endmodule

// File: tb/tb_image_page_pingpong.sv
// Bench for image_page_pingpong: page-level reference model checked every cycle,
// plus directed scenarios with hand-computed strip values.
module tb_image_page_pingpong;
    localparam int PIX_W  = 8;
    localparam int DEPTH  = 32;
    localparam int WR_PIX = 4;
    localparam int RD_PIX = 3;
    localparam int ADDR_W = 6;

    logic                     clk;
    logic                     rst;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [WR_PIX*PIX_W-1:0]  wr_data;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [RD_PIX*PIX_W-1:0]  rd_data;
    logic                     rd_valid;
    logic                     rd_page_valid;
    logic                     rd_release;
    logic                     rd_err;

    int n_vec = 0;
    int n_err = 0;

    image_page_pingpong #(
        .PIX_W(PIX_W), .IMG_W(8), .IMG_H(4), .DEPTH(DEPTH),
        .WR_PIX(WR_PIX), .RD_PIX(RD_PIX), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_page_valid(rd_page_valid), .rd_release(rd_release), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two whole pages as pixel arrays, advanced once per cycle.
    logic [7:0]  m_page [2][DEPTH];
    bit          m_full [2];
    int          m_ws, m_rs, m_cnt;
    bit          m_rv, m_err, m_init;
    logic [23:0] m_rd;

    initial m_init = 0;

    always @(negedge clk) begin
        int  ows, ors;
        bit  pv;
        if (m_init) begin
            chk("wr_ready",      wr_ready,      m_full[m_ws] ? 1'b0 : 1'b1);
            chk("rd_page_valid", rd_page_valid, m_full[m_rs]);
            chk("rd_valid",      rd_valid,      m_rv);
            chk("rd_err",        rd_err,        m_err);
            chk("rd_data",       rd_data,       m_rd);
        end
        if (rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_ws = 0; m_rs = 0; m_cnt = 0;
            m_rv = 0; m_err = 0; m_rd = '0;
            m_init = 1;
        end else if (m_init) begin
            ows = m_ws; ors = m_rs; pv = m_full[ors];
            m_rv = rd_en && pv;
            if (rd_en && pv) begin
                for (int i = 0; i < RD_PIX; i++) begin
                    int p;
                    p = int'(rd_addr) + i;
                    m_rd[i*8 +: 8] = (p < DEPTH) ? m_page[ors][p] : 8'h00;
                end
            end
            if (rd_en && !pv) m_err = 1;
            if (wr_valid && !m_full[ows]) begin
                for (int k = 0; k < WR_PIX; k++)
                    m_page[ows][m_cnt*WR_PIX + k] = wr_data[k*8 +: 8];
                if (m_cnt == DEPTH/WR_PIX - 1) begin
                    m_full[ows] = 1; m_ws = 1 - ows; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (rd_release && pv) begin
                m_full[ors] = 0; m_rs = 1 - ors;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_valid = 0; rd_en = 0; rd_release = 0;
    endtask

    task automatic do_reset;
        rst = 1; idle; step; rst = 0;
    endtask

    // Beats first..first+cnt-1 of a page whose pixel j holds base+j.
    task automatic fill(input logic [7:0] base, input int first, input int cnt,
                        input bit rel_last, input bit rd_each);
        for (int n = 0; n < cnt; n++) begin
            wr_valid = 1;
            for (int k = 0; k < WR_PIX; k++)
                wr_data[k*8 +: 8] = base + 8'(WR_PIX*(first+n) + k);
            if (rd_each) begin rd_en = 1; rd_addr = ADDR_W'(first + n); end
            if (rel_last && n == cnt-1) rd_release = 1;
            step;
            idle;
        end
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = ADDR_W'(a); step; idle;
    endtask

    task automatic release_pg;
        rd_release = 1; step; idle;
    endtask

    initial begin
        rst = 1; idle; wr_data = '0; rd_addr = '0;
        step; step; rst = 0;

        // 1: reset state, first page, first strip
        chk("rst wr_ready", wr_ready, 1'b1);
        chk("rst rd_page_valid", rd_page_valid, 1'b0);
        chk("rst rd_valid", rd_valid, 1'b0);
        chk("rst rd_data", rd_data, 24'h000000);
        chk("rst rd_err", rd_err, 1'b0);
        fill(8'h00, 0, 7, 0, 0);
        chk("s1 pv before beat8", rd_page_valid, 1'b0);
        fill(8'h00, 7, 1, 0, 0);
        chk("s1 pv after beat8", rd_page_valid, 1'b1);
        rd(5);
        chk("s1 rd5 valid", rd_valid, 1'b1);
        chk("s1 rd5 data", rd_data, 24'h070605);

        // 2: padding past the page end
        rd(30); chk("s2 rd30", rd_data, 24'h001F1E);
        rd(40); chk("s2 rd40", rd_data, 24'h000000);
        rd(29); chk("s2 rd29", rd_data, 24'h1F1E1D);
        step;
        chk("s2 idle valid", rd_valid, 1'b0);
        chk("s2 hold data", rd_data, 24'h1F1E1D);

        // 3: fill page 1 while reading page 0, then release
        fill(8'h80, 0, 1, 0, 1);
        chk("s3 rd0 page0", rd_data, 24'h020100);
        fill(8'h80, 1, 7, 0, 1);
        chk("s3 both full ready", wr_ready, 1'b0);
        wr_valid = 1; wr_data = 32'hFFFF_FFFF; step; idle;
        chk("s3 blocked ready", wr_ready, 1'b0);
        release_pg;
        chk("s3 pv after rel", rd_page_valid, 1'b1);
        chk("s3 ready after rel", wr_ready, 1'b1);
        rd(0);  chk("s3 rd0 page1", rd_data, 24'h828180);
        rd(29); chk("s3 rd29 page1", rd_data, 24'h9F9E9D);

        // 4: completion of page 1 coincides with release of page 0
        fill(8'h40, 0, 8, 0, 1);
        chk("s4 both full", wr_ready, 1'b0);
        release_pg;
        rd(0); chk("s4 rd0 page0", rd_data, 24'h424140);
        fill(8'hC0, 0, 7, 0, 0);
        fill(8'hC0, 7, 1, 1, 0);
        chk("s4 pv", rd_page_valid, 1'b1);
        chk("s4 ready", wr_ready, 1'b1);
        rd(3); chk("s4 rd3 page1", rd_data, 24'hC5C4C3);

        // 5: reads and release with no full page
        chk("s5 err clear", rd_err, 1'b0);
        release_pg;
        chk("s5 pv empty", rd_page_valid, 1'b0);
        release_pg;
        chk("s5 ignored rel", rd_page_valid, 1'b0);
        rd(0);
        chk("s5 no valid", rd_valid, 1'b0);
        chk("s5 err set", rd_err, 1'b1);
        chk("s5 data held", rd_data, 24'hC5C4C3);
        fill(8'h20, 0, 8, 0, 0);
        chk("s5 pv page0", rd_page_valid, 1'b1);
        rd(1);
        chk("s5 rd1", rd_data, 24'h232221);
        chk("s5 err sticky", rd_err, 1'b1);

        // 6: reset in the middle of a page
        do_reset;
        chk("s6 err cleared", rd_err, 1'b0);
        chk("s6 pv cleared", rd_page_valid, 1'b0);
        fill(8'hA0, 0, 5, 0, 0);
        do_reset;
        fill(8'h60, 0, 7, 0, 0);
        chk("s6 pv before beat8", rd_page_valid, 1'b0);
        fill(8'h60, 7, 1, 0, 0);
        chk("s6 pv after beat8", rd_page_valid, 1'b1);
        rd(0);  chk("s6 rd0", rd_data, 24'h626160);
        rd(29); chk("s6 rd29", rd_data, 24'h7F7E7D);

        step; step;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
